// File: rtl/alu_fu_if.sv
// alu_fu_if: issue, flush and CDB signals between the RS/ROB/arbiter side and the ALU unit
interface alu_fu_if;
  logic        flush;
  logic [4:0]  in_rs_id;
  logic [4:0]  in_roben;
  logic [11:0] in_opcode;
  logic [3:0]  in_aluop;
  logic [31:0] in_val1;
  logic [31:0] in_val2;
  logic [31:0] in_imm;
  logic        cdb_grant;
  logic        fu_is_free;
  logic        cdb_req;
  logic [4:0]  cdb_roben;
  logic [31:0] cdb_value;
  logic [4:0]  busy_rs_id;
  modport master (
    output flush, in_rs_id, in_roben, in_opcode, in_aluop, in_val1, in_val2, in_imm, cdb_grant,
    input  fu_is_free, cdb_req, cdb_roben, cdb_value, busy_rs_id
  );
  modport slave (
    input  flush, in_rs_id, in_roben, in_opcode, in_aluop, in_val1, in_val2, in_imm, cdb_grant,
    output fu_is_free, cdb_req, cdb_roben, cdb_value, busy_rs_id
  );
endinterface

// File: rtl/alu_fu_unit.sv
// alu_fu_unit: multi-cycle integer ALU that captures one RS issue and holds its result on the CDB until granted
module alu_fu_unit #(
  parameter int LATENCY = 2
) (
  input logic     clk,
  input logic     rst,
  alu_fu_if.slave fu
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [4:0]  rs_id_q;
  logic [4:0]  roben_q;
  logic [3:0]  aluop_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        free_q;
  logic        req_q;
  logic [4:0]  cdb_roben_q;
  logic [31:0] cdb_value_q;
  logic [31:0] res_d;
  assign fu.fu_is_free = free_q;
  assign fu.cdb_req    = req_q;
  assign fu.cdb_roben  = cdb_roben_q;
  assign fu.cdb_value  = cdb_value_q;
  assign fu.busy_rs_id = rs_id_q;
  // result of the captured operation, read only on the last EXEC edge
  always_comb begin
    res_d = '0;
    case (aluop_q)
      4'd0:    res_d = a_q + b_q;
      4'd1:    res_d = a_q - b_q;
      4'd2:    res_d = a_q & b_q;
      4'd3:    res_d = a_q | b_q;
      4'd4:    res_d = a_q ^ b_q;
      4'd5:    res_d = ~(a_q | b_q);
      4'd6:    res_d = a_q << b_q[4:0];
      4'd7:    res_d = a_q >> b_q[4:0];
      4'd8:    res_d = $unsigned($signed(a_q) >>> b_q[4:0]);
      4'd9:    res_d = {31'd0, $signed(a_q) < $signed(b_q)};
      4'd10:   res_d = {31'd0, a_q < b_q};
      default: res_d = '0;
    endcase
  end
  // issue/execute/broadcast FSM; flush outranks both grant and capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst || fu.flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rs_id_q     <= '0;
      roben_q     <= '0;
      aluop_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      free_q      <= 1'b1;
      req_q       <= 1'b0;
      cdb_roben_q <= '0;
      cdb_value_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (fu.in_rs_id != 5'd0) begin
          state_q <= EXEC;
          cnt_q   <= 4'(LATENCY);
          rs_id_q <= fu.in_rs_id;
          roben_q <= fu.in_roben;
          aluop_q <= fu.in_aluop;
          a_q     <= fu.in_val1;
          b_q     <= (fu.in_opcode[11:6] == 6'd0) ? fu.in_val2 : fu.in_imm;
          free_q  <= 1'b0;
        end
        EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= WAIT_CDB;
            req_q       <= 1'b1;
            cdb_roben_q <= roben_q;
            cdb_value_q <= res_d;
          end
        end
        WAIT_CDB: if (fu.cdb_grant) begin
          state_q     <= IDLE;
          rs_id_q     <= '0;
          roben_q     <= '0;
          free_q      <= 1'b1;
          req_q       <= 1'b0;
          cdb_roben_q <= '0;
          cdb_value_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_fu_unit.sv
// tb_alu_fu_unit: directed and randomized checks of alu_fu_unit against an arithmetic reference model
module tb_alu_fu_unit;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   rises = 0;
  logic prev_free = 1'b1;
  alu_fu_if fu ();
  alu_fu_unit #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .fu(fu.slave));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (fu.fu_is_free === 1'b1 && prev_free === 1'b0) rises++;
    prev_free = fu.fu_is_free;
  end
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ones = 32'hFFFF_FFFF;
    logic [31:0] flip = 32'h8000_0000;
    int unsigned s = 32'(b[4:0]);
    case (op)
      0: return a + b;
      1: return a + ~b + 32'd1;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return a << s;
      7: return a >> s;
      8: return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      9: return ((a ^ flip) < (b ^ flip)) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [4:0] rs, input logic [4:0] rob, input logic [11:0] opc, input logic [3:0] op,
                     input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm, input int hold);
    logic [31:0] exp;
    exp = ref_alu(int'(op), v1, (opc[11:6] == 6'd0) ? v2 : imm);
    @(negedge clk);
    fu.in_rs_id = rs; fu.in_roben = rob; fu.in_opcode = opc; fu.in_aluop = op;
    fu.in_val1 = v1; fu.in_val2 = v2; fu.in_imm = imm; fu.cdb_grant = (hold == 0);
    step();
    chk("cap_free", 32'(fu.fu_is_free), 32'd0);
    chk("cap_busy", 32'(fu.busy_rs_id), 32'(rs));
    chk("cap_req", 32'(fu.cdb_req), 32'd0);
    for (int i = 1; i < LAT; i++) begin
      step();
      chk("exec_req", 32'(fu.cdb_req), 32'd0);
    end
    step();
    chk("res_req", 32'(fu.cdb_req), 32'd1);
    chk("res_roben", 32'(fu.cdb_roben), 32'(rob));
    chk("res_value", fu.cdb_value, exp);
    chk("res_free", 32'(fu.fu_is_free), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_req", 32'(fu.cdb_req), 32'd1);
      chk("hold_roben", 32'(fu.cdb_roben), 32'(rob));
      chk("hold_value", fu.cdb_value, exp);
      chk("hold_free", 32'(fu.fu_is_free), 32'd0);
    end
    if (hold > 0) begin
      @(negedge clk);
      fu.cdb_grant = 1'b1;
    end
    step();
    chk("rel_req", 32'(fu.cdb_req), 32'd0);
    chk("rel_free", 32'(fu.fu_is_free), 32'd1);
    chk("rel_busy", 32'(fu.busy_rs_id), 32'd0);
    chk("rel_roben", 32'(fu.cdb_roben), 32'd0);
    chk("rel_value", fu.cdb_value, 32'd0);
  endtask
  initial begin
    int r0;
    fu.flush = 1'b0; fu.in_rs_id = '0; fu.in_roben = '0; fu.in_opcode = '0; fu.in_aluop = '0;
    fu.in_val1 = '0; fu.in_val2 = '0; fu.in_imm = '0; fu.cdb_grant = 1'b0;
    step();
    chk("rst_free", 32'(fu.fu_is_free), 32'd1);
    chk("rst_req", 32'(fu.cdb_req), 32'd0);
    chk("rst_roben", 32'(fu.cdb_roben), 32'd0);
    chk("rst_value", fu.cdb_value, 32'd0);
    chk("rst_busy", 32'(fu.busy_rs_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(5'd3, 5'd7, 12'h000, 4'd0, 32'd5, 32'd9, 32'd0, 0);
    run(5'd4, 5'd2, 12'h200, 4'd1, 32'd10, 32'd99, 32'd3, 0);
    run(5'd5, 5'd0, 12'h000, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run(5'd6, 5'd9, 12'h000, 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run(5'd8, 5'd11, 12'h000, 4'd8, 32'h8000_0F00, 32'd4, 32'd0, 5);
    @(negedge clk);
    fu.in_rs_id = 5'd9; fu.cdb_grant = 1'b0;
    step();
    chk("fl_cap_free", 32'(fu.fu_is_free), 32'd0);
    @(negedge clk);
    fu.flush = 1'b1; fu.in_rs_id = '0;
    step();
    chk("fl_free", 32'(fu.fu_is_free), 32'd1);
    chk("fl_busy", 32'(fu.busy_rs_id), 32'd0);
    @(negedge clk);
    fu.flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_noreq", 32'(fu.cdb_req), 32'd0);
      chk("fl_idle", 32'(fu.fu_is_free), 32'd1);
    end
    @(negedge clk);
    fu.in_rs_id = 5'd12; fu.in_roben = 5'd13; fu.in_opcode = '0; fu.in_aluop = 4'd0;
    fu.in_val1 = 32'd1; fu.in_val2 = 32'd2;
    repeat (LAT + 1) step();
    chk("ar_pre_req", 32'(fu.cdb_req), 32'd1);
    @(negedge clk);
    fu.in_rs_id = '0;
    #2 rst = 1'b1;
    #1;
    chk("ar_req", 32'(fu.cdb_req), 32'd0);
    chk("ar_free", 32'(fu.fu_is_free), 32'd1);
    chk("ar_roben", 32'(fu.cdb_roben), 32'd0);
    chk("ar_value", fu.cdb_value, 32'd0);
    chk("ar_busy", 32'(fu.busy_rs_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_free", 32'(fu.fu_is_free), 32'd1);
      chk("idle_busy", 32'(fu.busy_rs_id), 32'd0);
    end
    r0 = rises;
    run(5'd1, 5'd20, 12'h000, 4'd4, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 0);
    run(5'd2, 5'd21, 12'h040, 4'd6, 32'h0000_0001, 32'd0, 32'd31, 0);
    @(negedge clk);
    fu.in_rs_id = '0;
    #1;
    chk("b2b_rises", 32'(rises - r0), 32'd2);
    for (int n = 0; n < 30; n++) begin
      logic [11:0] opc;
      opc = ($urandom_range(0, 1) == 0) ? {6'd0, 6'($urandom)} : 12'($urandom);
      run(5'($urandom_range(1, 31)), 5'($urandom), opc, 4'($urandom_range(0, 15)),
          $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
